// File: rtl/oflow_mem_buffer_hist_ctrl.sv
// oflow_mem_buffer_hist_ctrl: circular frame-history bbox store, NUM_CH records/line write and newest-first read.
// Define OFLOW_MEM_BUF_PARITY_EN to store an even-parity bit per entry and expose a sticky parity_err.
module oflow_mem_buffer_hist_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CH          = 2,
  parameter int MAX_HIST_FRAMES = 4,
  parameter int MAX_BBOX        = 16,
  parameter int HIST_W          = $clog2(MAX_HIST_FRAMES + 1),
  parameter int BBOX_W          = $clog2(MAX_BBOX + 1)
) (
  input  logic                         clk,
  input  logic                         reset_N,
  input  logic                         start_write,
  input  logic                         start_read,
  input  logic                         data_in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         read_new_line,
  input  logic [HIST_W-1:0]            num_of_history_frames,
  input  logic [BBOX_W-1:0]            num_of_bbox_in_frame,
  output logic                         busy,
  output logic                         done_write,
  output logic                         done_read,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            data_out_valid,
  output logic                         line_valid,
  output logic [HIST_W-1:0]            counter_of_history_frame_to_interface,
  output logic [HIST_W-1:0]            valid_frames
`ifdef OFLOW_MEM_BUF_PARITY_EN
  ,output logic                        parity_err
`endif
);
  localparam int LINES  = MAX_BBOX / NUM_CH;
  localparam int SLOT_W = MAX_HIST_FRAMES > 1 ? $clog2(MAX_HIST_FRAMES) : 1;
  localparam int LINE_W = $clog2(LINES + 1);
  localparam int DEPTH  = MAX_HIST_FRAMES * LINES;
  localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef OFLOW_MEM_BUF_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE_WR, DONE_RD} state_t;

  state_t              state, state_nx;
  logic [SLOT_W-1:0]   wr_slot, rd_slot;
  logic [LINE_W-1:0]   line;
  logic [HIST_W-1:0]   k, h_lat, h_req;
  logic [BBOX_W-1:0]   n_lat;
  logic [NUM_CH-1:0]   ch_ok;
  logic                last_line;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  int                  rs;
  logic [MW-1:0]       mem [DEPTH][NUM_CH];

  always_comb begin
    h_req     = num_of_history_frames < valid_frames ? num_of_history_frames : valid_frames;
    last_line = (int'(line) + 1) * NUM_CH >= int'(n_lat);
    rs        = int'(wr_slot) + MAX_HIST_FRAMES - int'(k);
    rd_slot   = SLOT_W'(rs >= MAX_HIST_FRAMES ? rs - MAX_HIST_FRAMES : rs);
    wr_addr   = ADDR_W'(int'(wr_slot) * LINES + int'(line));
    rd_addr   = ADDR_W'(int'(rd_slot) * LINES + int'(line));
    ch_ok     = '0;
    for (int c = 0; c < NUM_CH; c++)
      ch_ok[c] = int'(line) * NUM_CH + c < int'(n_lat);
  end

  always_ff @(posedge clk)
    state <= reset_N ? IDLE : state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start_write ? WRITE : !start_read ? IDLE :
                           (h_req == '0 || num_of_bbox_in_frame == '0) ? DONE_RD : RD_ISSUE;
      WRITE:    state_nx = (n_lat == '0 || (data_in_valid && last_line)) ? DONE_WR : WRITE;
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = !read_new_line ? RD_WAIT : (last_line && k == h_lat) ? DONE_RD : RD_ISSUE;
      default:  state_nx = IDLE;
    endcase
  end

  assign busy       = state != IDLE;
  assign done_write = state == DONE_WR;
  assign done_read  = state == DONE_RD;
  assign counter_of_history_frame_to_interface = (state == RD_ISSUE || state == RD_WAIT) ? k : '0;

  // Only channels inside the frame's record count are stored; the rest of the line keeps old content.
  always_ff @(posedge clk)
    if (state == WRITE && data_in_valid && int'(line) < LINES)
      for (int c = 0; c < NUM_CH; c++)
        if (ch_ok[c])
`ifdef OFLOW_MEM_BUF_PARITY_EN
          mem[wr_addr][c] <= {^data_in[c*DATA_WIDTH +: DATA_WIDTH], data_in[c*DATA_WIDTH +: DATA_WIDTH]};
`else
          mem[wr_addr][c] <= data_in[c*DATA_WIDTH +: DATA_WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (reset_N) begin
      wr_slot        <= '0;
      valid_frames   <= '0;
      line           <= '0;
      k              <= '0;
      h_lat          <= '0;
      n_lat          <= '0;
      data_out       <= '0;
      data_out_valid <= '0;
      line_valid     <= 1'b0;
`ifdef OFLOW_MEM_BUF_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else begin
      line_valid <= state == RD_ISSUE;
      case (state)
        IDLE: begin
          line  <= '0;
          k     <= HIST_W'(1);
          h_lat <= h_req;
          if (start_write || start_read) n_lat <= num_of_bbox_in_frame;
`ifdef OFLOW_MEM_BUF_PARITY_EN
          if (start_read && !start_write) parity_err <= 1'b0;
`endif
        end
        WRITE: if (data_in_valid) line <= line + LINE_W'(1);
        DONE_WR: begin
          wr_slot <= int'(wr_slot) == MAX_HIST_FRAMES - 1 ? '0 : wr_slot + SLOT_W'(1);
          if (int'(valid_frames) != MAX_HIST_FRAMES) valid_frames <= valid_frames + HIST_W'(1);
        end
        RD_ISSUE: begin
          data_out_valid <= ch_ok;
          for (int c = 0; c < NUM_CH; c++) begin
            data_out[c*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_addr][c][DATA_WIDTH-1:0];
`ifdef OFLOW_MEM_BUF_PARITY_EN
            if (ch_ok[c] && ^mem[rd_addr][c]) parity_err <= 1'b1;
`endif
          end
        end
        RD_WAIT: if (read_new_line) begin
          line <= last_line ? '0 : line + LINE_W'(1);
          if (last_line) k <= k + HIST_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oflow_mem_buffer_hist_ctrl.sv
// tb_oflow_mem_buffer_hist_ctrl: randomized scoreboard bench for the frame-history buffer.
module tb_oflow_mem_buffer_hist_ctrl;
  localparam int DW = 32, NC = 2, M = 4, MB = 16, HW = 3, BW = 5;

  logic clk = 0, reset_N = 1, start_write = 0, start_read = 0, data_in_valid = 0, read_new_line = 0;
  logic [NC*DW-1:0] data_in = '0;
  logic [HW-1:0] num_of_history_frames = '0;
  logic [BW-1:0] num_of_bbox_in_frame = '0;
  logic busy, done_write, done_read, line_valid;
  logic [NC*DW-1:0] data_out;
  logic [NC-1:0] data_out_valid;
  logic [HW-1:0] counter, valid_frames;

  oflow_mem_buffer_hist_ctrl #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_HIST_FRAMES(M), .MAX_BBOX(MB)) dut (
    .clk(clk), .reset_N(reset_N), .start_write(start_write), .start_read(start_read),
    .data_in_valid(data_in_valid), .data_in(data_in), .read_new_line(read_new_line),
    .num_of_history_frames(num_of_history_frames), .num_of_bbox_in_frame(num_of_bbox_in_frame),
    .busy(busy), .done_write(done_write), .done_read(done_read), .data_out(data_out),
    .data_out_valid(data_out_valid), .line_valid(line_valid),
    .counter_of_history_frame_to_interface(counter), .valid_frames(valid_frames));

  always #5 clk = ~clk;

  typedef struct {
    logic [NC*DW-1:0] data;
    logic [NC-1:0]    mask;
    logic [NC-1:0]    known;
    logic [HW-1:0]    ctr;
  } line_t;

  line_t sb[$];
  int total = 0, passed = 0;
  logic [DW-1:0] mdl [M][MB];
  bit kn [M][MB];
  int m_slot = 0, m_valid = 0;

  task automatic chk(string name, logic [NC*DW-1:0] act, logic [NC*DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every line_valid pulse must match the oldest expected line
  always @(negedge clk) begin
    line_t e;
    if (!reset_N && line_valid) begin
      if (sb.size() == 0) chk("unexpected_line", 1, 0);
      else begin
        e = sb.pop_front();
        chk("line_mask", data_out_valid, e.mask);
        chk("line_counter", counter, e.ctr);
        for (int c = 0; c < NC; c++)
          if (e.mask[c] && e.known[c]) chk("line_data", data_out[c*DW +: DW], e.data[c*DW +: DW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: newest frame first, ceil(n/NC) lines each, depth clamped to stored frames
  function automatic int expect_read(int h, int n);
    int hh = h < m_valid ? h : m_valid;
    int nl = (n + NC - 1) / NC;
    int cnt = 0;
    line_t e;
    if (n == 0) return 0;
    for (int f = 1; f <= hh; f++) begin
      int s = (m_slot - f + M) % M;
      for (int l = 0; l < nl; l++) begin
        for (int c = 0; c < NC; c++) begin
          int idx = l * NC + c;
          e.mask[c]  = idx < n;
          e.known[c] = idx < MB && kn[s][idx];
          e.data[c*DW +: DW] = idx < MB ? mdl[s][idx] : '0;
        end
        e.ctr = HW'(f);
        sb.push_back(e);
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic do_write(int n, bit also_read);
    logic [DW-1:0] rec [MB];
    bit seen = 0;
    int beats = (n + NC - 1) / NC;
    for (int i = 0; i < MB; i++) rec[i] = $urandom;
    num_of_bbox_in_frame = BW'(n);
    num_of_history_frames = HW'(M);
    start_write = 1;
    start_read = also_read;
    tick();
    start_write = 0;
    start_read = 0;
    for (int b = 0; b < beats; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      for (int c = 0; c < NC; c++)
        data_in[c*DW +: DW] = (b * NC + c < n) ? rec[b*NC + c] : $urandom;
      data_in_valid = 1;
      tick();
      data_in_valid = 0;
    end
    for (int i = 0; i < MB; i++) begin
      kn[m_slot][i] = i < n;
      if (i < n) mdl[m_slot][i] = rec[i];
    end
    m_slot = (m_slot + 1) % M;
    m_valid = m_valid < M ? m_valid + 1 : M;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (done_write) seen = 1;
      else tick();
    end
    chk("done_write", seen, 1);
    tick();
    chk("valid_frames", valid_frames, m_valid);
    if (also_read) begin
      tick();
      tick();
      chk("dropped_read", {busy, done_read}, 0);
    end
  endtask

  task automatic do_read(int h, int n, int bp_first);
    bit seen = 0;
    int lines = 0, bp, exp_lines;
    logic [NC*DW-1:0] hold;
    num_of_history_frames = HW'(h);
    num_of_bbox_in_frame = BW'(n);
    exp_lines = expect_read(h, n);
    start_read = 1;
    tick();
    start_read = 0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (done_read) seen = 1;
      else if (line_valid) begin
        bp = lines == 0 ? bp_first : $urandom_range(0, 2);
        hold = data_out;
        lines++;
        repeat (bp) tick();
        if (bp > 0) begin
          chk("bp_data_hold", data_out, hold);
          chk("bp_line_valid_low", line_valid, 0);
        end
        read_new_line = 1;
        tick();
        read_new_line = 0;
      end else tick();
    end
    chk("done_read", seen, 1);
    chk("line_count", lines, exp_lines);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    tick();
    chk("idle_after_read", {busy, counter}, 0);
  endtask

  task automatic do_reset();
    reset_N = 1;
    tick();
    tick();
    reset_N = 0;
    m_slot = 0;
    m_valid = 0;
    sb.delete();
  endtask

  initial begin
    bit bad = 0, got_line = 0;
    int dummy;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done_write", done_write, 0);
    chk("rst_done_read", done_read, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_out_valid", data_out_valid, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_counter", counter, 0);
    chk("rst_valid_frames", valid_frames, 0);
    reset_N = 0;
    tick();
    do_read(2, 4, 0);
    do_write(5, 0);
    do_read(1, 5, 10);
    repeat (6) do_write(2, 0);
    do_read(4, 2, 1);
    do_reset();
    do_write(3, 0);
    do_write(3, 0);
    do_read(4, 3, 0);
    do_write(4, 1);
    do_write(0, 0);
    do_read(3, 4, 0);
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, MB), 0);
      else do_read($urandom_range(0, M), $urandom_range(0, MB), $urandom_range(0, 3));
    end
    // Abort a read mid-stream with reset
    if (m_valid == 0) do_write(4, 0);
    num_of_history_frames = HW'(M);
    num_of_bbox_in_frame = BW'(4);
    dummy = expect_read(M, 4);
    start_read = 1;
    tick();
    start_read = 0;
    for (int i = 0; i < 10 && !got_line; i++) begin
      if (line_valid) got_line = 1;
      else tick();
    end
    chk("line_before_reset", got_line, 1);
    reset_N = 1;
    tick();
    reset_N = 0;
    sb.delete();
    m_slot = 0;
    m_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid_frames", valid_frames, 0);
    chk("abort_counter", counter, 0);
    repeat (5) begin
      if (done_read || line_valid) bad = 1;
      tick();
    end
    chk("abort_no_done", bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
